udp_recv: RTL

Receive-side UDP parser sitting directly downstream of the IPv4 receive stage. It consumes the IP payload byte stream, qualified by the IP stage's `active` strobe. It extracts source port, destination port and length from the 8-byte UDP header. It then gates the UDP payload bytes to the protocol consumers, with end-of-packet and length-error indications.

---
 rtl/udp_recv_if.sv | 23 ++
 rtl/udp_recv.sv | 114 +++++++++++
 2 files changed

// File: rtl/udp_recv_if.sv
// udp_recv stream interface: IP payload bytes in, parsed UDP header fields and payload strobes out.
// master = IP stage / consumer side, slave = udp_recv.
interface udp_recv_if;
    logic        rx_enable;
    logic [7:0]  data;
    logic        active;
    logic [15:0] from_port;
    logic [15:0] to_port;
    logic [15:0] payload_len;
    logic [15:0] byte_no;
    logic        packet_done;
    logic        length_error;

    modport master (
        output rx_enable, data,
        input  active, from_port, to_port, payload_len, byte_no, packet_done, length_error
    );

    modport slave (
        input  rx_enable, data,
        output active, from_port, to_port, payload_len, byte_no, packet_done, length_error
    );
endinterface

// File: rtl/udp_recv.sv
// UDP receive parser: extracts ports/length from the 8-byte header and gates payload bytes.
// Optional destination-port filtering is compiled in with `UDP_PORT_FILTER_EN.
module udp_recv #(
    parameter logic [15:0] LOCAL_PORT = 16'd1024
) (
    input  logic         clock,
    input  logic         reset,
    udp_recv_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_rx_q;
    logic [3:0]  r_hdr_cnt;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [15:0] r_from_port;
    logic [15:0] r_to_port;
    logic [15:0] r_payload_len;
    logic        r_done;
    logic        r_err;

`ifndef UDP_PORT_FILTER_EN
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, LOCAL_PORT};
`endif

    // r_rx_q resets high so a datagram already in flight at reset is skipped until rx_enable re-rises.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rx_q        <= 1'b1;
            r_hdr_cnt     <= 4'd0;
            r_len         <= 16'd0;
            r_cnt         <= 16'd0;
            r_from_port   <= 16'd0;
            r_to_port     <= 16'd0;
            r_payload_len <= 16'd0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rx_q <= bus.rx_enable;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (!bus.rx_enable) begin
                r_err   <= (r_state == S_HEADER) || (r_state == S_PAYLOAD);
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_q) begin
                            r_from_port[15:8] <= bus.data;
                            r_hdr_cnt         <= 4'd2;
                            r_state           <= S_HEADER;
                        end
                    end
                    S_HEADER: begin
                        r_hdr_cnt <= r_hdr_cnt + 4'd1;
                        case (r_hdr_cnt)
                            4'd2: r_from_port[7:0]  <= bus.data;
                            4'd3: r_to_port[15:8]   <= bus.data;
                            4'd4: begin
                                r_to_port[7:0] <= bus.data;
`ifdef UDP_PORT_FILTER_EN
                                if ({r_to_port[15:8], bus.data} != LOCAL_PORT) begin
                                    r_state <= S_DONE;
                                end
`endif
                            end
                            4'd5: r_len[15:8] <= bus.data;
                            4'd6: r_len[7:0]  <= bus.data;
                            4'd8: begin
                                if (r_len < 16'd8) begin
                                    r_err   <= 1'b1;
                                    r_state <= S_DONE;
                                end else if (r_len == 16'd8) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_payload_len <= r_len - 16'd8;
                                    r_cnt         <= 16'd0;
                                    r_state       <= S_PAYLOAD;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_PAYLOAD: begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == r_payload_len - 16'd1) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.active       = bus.rx_enable & (r_state == S_PAYLOAD);
    assign bus.byte_no      = r_cnt;
    assign bus.from_port    = r_from_port;
    assign bus.to_port      = r_to_port;
    assign bus.payload_len  = r_payload_len;
    assign bus.packet_done  = r_done;
    assign bus.length_error = r_err;
endmodule
